// File: rtl/sail_mem_pkg.sv
// Shared state encoding, access-size codes and helpers for the sail-core data-port sequencer.
package sail_mem_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } state_t;

  localparam logic [2:0] SZ_BYTE  = 3'b001;
  localparam logic [2:0] SZ_HALF  = 3'b011;
  localparam logic [2:0] SZ_WORD  = 3'b111;
  localparam int         SIGN_BIT = 3;

  function automatic logic size_ok(input logic [2:0] size);
    return (size == SZ_BYTE) || (size == SZ_HALF) || (size == SZ_WORD);
  endfunction

  function automatic logic misaligned(input logic [2:0] size, input logic [1:0] lo);
    return ((size == SZ_HALF) && lo[0]) || ((size == SZ_WORD) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/rmw_lane_unit.sv
// Byte/halfword lane logic: merges store data into a read word and extracts
// aligned, sign- or zero-extended load data from it.
module rmw_lane_unit
  import sail_mem_pkg::*;
(
  input  logic [31:0] word_buf,
  input  logic [31:0] wdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  size,
  input  logic        sign,
  output logic [31:0] merged,
  output logic [31:0] extracted
);

  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    byte_sh   = {addr_lo, 3'b000};
    half_sh   = {addr_lo[1], 4'b0000};
    sel_byte  = word_buf[byte_sh +: 8];
    sel_half  = word_buf[half_sh +: 16];
    merged    = word_buf;
    extracted = '0;
    case (size)
      SZ_BYTE: begin
        merged[byte_sh +: 8] = wdata[7:0];
        extracted = {{24{sign & sel_byte[7]}}, sel_byte};
      end
      SZ_HALF: begin
        merged[half_sh +: 16] = wdata[15:0];
        extracted = {{16{sign & sel_half[15]}}, sel_half};
      end
      SZ_WORD: begin
        merged    = wdata;
        extracted = word_buf;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/data_mem_rmw_ctrl.sv
// Data-port sequencer: one load/store at a time into a 1-cycle-latency BRAM, RMW for sub-word stores.
// Build option MISALIGN_TRAP_EN: misaligned halfword/word accesses answer with rsp_err and skip memory.
module data_mem_rmw_ctrl
  import sail_mem_pkg::*;
#(
  parameter int MEM_ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [3:0]            req_sign_mask,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  output state_t                dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // valid never depends on ready, and once raised rsp_valid/rsp_rdata/rsp_err hold until taken.

  state_t                state;
  logic                  we_q;
  logic [MEM_ADDR_W+1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            mask_q;
  logic [31:0]           word_buf;
  logic [31:0]           merged;
  logic [31:0]           extracted;
  logic                  err_q;
  logic                  trap;
  logic                  unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:MEM_ADDR_W+2];

  always_comb begin
`ifdef MISALIGN_TRAP_EN
    trap = misaligned(req_sign_mask[2:0], req_addr[1:0]);
`else
    trap = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      mask_q    <= '0;
      word_buf  <= '0;
`ifdef MISALIGN_TRAP_EN
      err_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            we_q      <= req_we;
            addr_q    <= req_addr[MEM_ADDR_W+1:0];
            wdata_q   <= req_wdata;
            mask_q    <= req_sign_mask;
            req_ready <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            err_q     <= trap;
`endif
            // Unsupported sizes and trapped accesses never touch the BRAM.
            if (!size_ok(req_sign_mask[2:0]) || trap) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
            end else if (req_we && (req_sign_mask[2:0] == SZ_WORD)) begin
              state  <= WR;
              mem_we <= 1'b1;
            end else begin
              state  <= RD;
              mem_re <= 1'b1;
            end
          end
        end
        RD: begin
          mem_re <= 1'b0;
          state  <= CAP;
        end
        CAP: begin
          word_buf <= mem_rdata;
          if (we_q) begin
            state  <= WR;
            mem_we <= 1'b1;
          end else begin
            state     <= RESP;
            rsp_valid <= 1'b1;
          end
        end
        WR: begin
          mem_we    <= 1'b0;
          state     <= RESP;
          rsp_valid <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
`ifdef MISALIGN_TRAP_EN
            err_q     <= 1'b0;
`endif
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          mem_re    <= 1'b0;
          mem_we    <= 1'b0;
        end
      endcase
    end
  end

`ifndef MISALIGN_TRAP_EN
  assign err_q = 1'b0;
`endif

  rmw_lane_unit u_lane (
    .word_buf  (word_buf),
    .wdata     (wdata_q),
    .addr_lo   (addr_q[1:0]),
    .size      (mask_q[2:0]),
    .sign      (mask_q[SIGN_BIT]),
    .merged    (merged),
    .extracted (extracted)
  );

  // Outputs below decode registered state only, so they are stable for the whole cycle.
  assign mem_addr  = addr_q[MEM_ADDR_W+1:2];
  assign mem_wdata = mem_we ? merged : '0;
  assign rsp_rdata = ((state == RESP) && !we_q && size_ok(mask_q[2:0]) && !err_q) ? extracted : '0;
  assign rsp_err   = err_q;
  assign dbg_state = state;

endmodule
